// File: rtl/ngram_encoder_param_if.sv
// Handshake and data bundle between the spatial encoder, the N-gram encoder and the
// associative memory.
interface ngram_encoder_param_if #(
  parameter int unsigned HV_DIMENSION = 2048,
  parameter int unsigned NSIZE_W      = 3
);
  logic                    Clear_SI;
  logic [NSIZE_W-1:0]      NGramSize_SI;
  logic                    ValidIn_SI;
  logic                    ReadyOut_SO;
  logic [0:HV_DIMENSION-1] HypervectorIn_DI;
  logic                    ValidOut_SO;
  logic                    ReadyIn_SI;
  logic [0:HV_DIMENSION-1] HypervectorOut_DO;
  logic                    Primed_SO;

  modport master (
    output Clear_SI, NGramSize_SI, ValidIn_SI, HypervectorIn_DI, ReadyIn_SI,
    input  ReadyOut_SO, ValidOut_SO, HypervectorOut_DO, Primed_SO
  );

  modport slave (
    input  Clear_SI, NGramSize_SI, ValidIn_SI, HypervectorIn_DI, ReadyIn_SI,
    output ReadyOut_SO, ValidOut_SO, HypervectorOut_DO, Primed_SO
  );
endinterface

// File: rtl/ngram_encoder_param.sv
// Temporal N-gram encoder: binds each accepted hypervector with up to NGRAM_MAX-1
// rotated predecessors; run-time gram size, warm-up suppression, one-deep output buffer.
module ngram_encoder_param #(
  parameter int unsigned HV_DIMENSION = 2048,
  parameter int unsigned NGRAM_MAX    = 5,
  parameter int unsigned NSIZE_W      = 3
) (
  input logic                  Clk_CI,
  input logic                  Reset_RI,
  ngram_encoder_param_if.slave bus
);

  localparam int unsigned        HIST  = NGRAM_MAX - 1;
  localparam logic [NSIZE_W-1:0] N_MAX = NSIZE_W'(NGRAM_MAX);
  localparam logic [NSIZE_W-1:0] F_MAX = NSIZE_W'(NGRAM_MAX - 1);
  localparam logic [NSIZE_W-1:0] N_ONE = NSIZE_W'(1);

  typedef enum logic [1:0] {WARMUP, RUN, HOLD} state_t;

  state_t                  state_q, state_d;
  logic [0:HV_DIMENSION-1] hist_q [1:HIST];
  logic [0:HV_DIMENSION-1] hist_d [1:HIST];
  logic [NSIZE_W-1:0]      n_q, n_d;
  logic [NSIZE_W-1:0]      f_q, f_d;
  logic                    valid_q, valid_d;
  logic [0:HV_DIMENSION-1] out_q, out_d;
  logic [0:HV_DIMENSION-1] gram;
  logic                    ready, accept, load, primed;

  // Index 0 is the MSB, so this is a numeric rotate-right by one.
  function automatic logic [0:HV_DIMENSION-1] rho(input logic [0:HV_DIMENSION-1] x);
    return {x[HV_DIMENSION-1], x[0:HV_DIMENSION-2]};
  endfunction

  assign primed = (state_q != WARMUP);
  assign ready  = ~bus.Clear_SI & (~valid_q | bus.ReadyIn_SI);
  assign accept = bus.ValidIn_SI & ready;
  assign load   = accept & primed;

  always_comb begin
    gram = bus.HypervectorIn_DI;
    for (int unsigned k = 1; k <= HIST; k++) begin
      if (k < 32'(n_q)) gram = gram ^ hist_q[k];
    end
  end

  always_comb begin
    n_d     = n_q;
    f_d     = f_q;
    out_d   = out_q;
    valid_d = valid_q;
    state_d = state_q;
    for (int unsigned k = 1; k <= HIST; k++) hist_d[k] = hist_q[k];

    if (load) begin
      out_d   = gram;
      valid_d = 1'b1;
    end else if (bus.ReadyIn_SI) begin
      valid_d = 1'b0;
    end

    if (bus.Clear_SI) begin
      for (int unsigned k = 1; k <= HIST; k++) hist_d[k] = '0;
      f_d = '0;
      if (bus.NGramSize_SI <= N_ONE)     n_d = N_ONE;
      else if (bus.NGramSize_SI > N_MAX) n_d = N_MAX;
      else                               n_d = bus.NGramSize_SI;
      // A pending output survives the flush, so N=1 lands in HOLD while it waits.
      if (n_d != N_ONE) state_d = WARMUP;
      else              state_d = valid_d ? HOLD : RUN;
    end else begin
      if (accept) begin
        hist_d[1] = rho(bus.HypervectorIn_DI);
        for (int unsigned k = 2; k <= HIST; k++) hist_d[k] = rho(hist_q[k-1]);
        if (f_q != F_MAX) f_d = f_q + 1'b1;
      end
      case (state_q)
        WARMUP:  if (f_d >= n_q - N_ONE) state_d = valid_d ? HOLD : RUN;
        RUN:     if (valid_d) state_d = HOLD;
        HOLD:    if (!valid_d) state_d = RUN;
        default: state_d = WARMUP;
      endcase
    end
  end

  always_ff @(posedge Clk_CI or posedge Reset_RI) begin
    if (Reset_RI) begin
      state_q <= WARMUP;
      n_q     <= N_MAX;
      f_q     <= '0;
      valid_q <= 1'b0;
      out_q   <= '0;
      for (int unsigned k = 1; k <= HIST; k++) hist_q[k] <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      f_q     <= f_d;
      valid_q <= valid_d;
      out_q   <= out_d;
      for (int unsigned k = 1; k <= HIST; k++) hist_q[k] <= hist_d[k];
    end
  end

  assign bus.ReadyOut_SO       = ready;
  assign bus.ValidOut_SO       = valid_q;
  assign bus.HypervectorOut_DO = out_q;
  assign bus.Primed_SO         = primed;

endmodule
